// File: rtl/smart_home_pkg.sv
// smart_home_pkg: shared motion-interface state encoding and default timing constants.
package smart_home_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        ACTIVE,
        HOLD,
        BLANK,
        FAULT
    } motion_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_BLANK_CYCLES    = 8;
    localparam int DEF_STUCK_CYCLES    = 1024;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// input_synchronizer: multi-flop synchroniser for a single asynchronous input.
module input_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ff <= '0;
        else       r_ff <= {r_ff[STAGES-2:0], i_d};
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/pir_motion_conditioner.sv
// pir_motion_conditioner: synchronises, debounces and holds a raw PIR line into a clean
// motion level, with post-hold blanking and stuck-high fault detection.
module pir_motion_conditioner
    import smart_home_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pir_raw,
    input  logic sensor_enable,
    output logic motion_detected,
    output logic motion_event,
    output logic sensor_fault
);

    localparam int CW = $clog2(max2(max2(DEBOUNCE_CYCLES, HOLD_CYCLES),
                                    max2(BLANK_CYCLES, STUCK_CYCLES))) + 1;
    localparam logic [CW-1:0] C_DEB   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] C_STUCK = CW'(STUCK_CYCLES - 1);

    motion_state_t r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_ncnt;
    logic          w_s, w_event;

    input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pir_raw),
        .o_q   (w_s)
    );

    // One shared counter; every state change clears it except IDLE->QUALIFY, which counts the first sample.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + 1'b1;
        if (!sensor_enable) begin
            w_nstate = IDLE;
            w_ncnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nstate = w_s ? ((DEBOUNCE_CYCLES == 1) ? ACTIVE : QUALIFY) : IDLE;
                    w_ncnt   = (w_s && DEBOUNCE_CYCLES != 1) ? CW'(1) : '0;
                end
                QUALIFY: begin
                    if (!w_s)                 begin w_nstate = IDLE;   w_ncnt = '0; end
                    else if (r_cnt == C_DEB)  begin w_nstate = ACTIVE; w_ncnt = '0; end
                end
                ACTIVE: begin
                    if (!w_s)                  begin w_nstate = HOLD;  w_ncnt = '0; end
                    else if (r_cnt == C_STUCK) begin w_nstate = FAULT; w_ncnt = '0; end
                end
                HOLD: begin
                    if (w_s)                  begin w_nstate = ACTIVE; w_ncnt = '0; end
                    else if (r_cnt == C_HOLD) begin w_nstate = BLANK;  w_ncnt = '0; end
                end
                BLANK: begin
                    if (r_cnt == C_BLANK) begin w_nstate = IDLE; w_ncnt = '0; end
                end
                FAULT: begin
                    if (w_s)                  w_ncnt = '0;
                    else if (r_cnt == C_DEB)  begin w_nstate = IDLE; w_ncnt = '0; end
                end
                default: begin
                    w_nstate = IDLE;
                    w_ncnt   = '0;
                end
            endcase
        end
    end

    // A HOLD->ACTIVE retrigger is not a new detection.
    assign w_event = (w_nstate == ACTIVE) && (r_state == IDLE || r_state == QUALIFY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            motion_detected <= 1'b0;
            motion_event    <= 1'b0;
            sensor_fault    <= 1'b0;
        end else begin
            r_state         <= w_nstate;
            r_cnt           <= w_ncnt;
            motion_detected <= (w_nstate == ACTIVE) || (w_nstate == HOLD);
            motion_event    <= w_event;
            sensor_fault    <= (w_nstate == FAULT);
        end
    end

endmodule
